// File: rtl/seq_mul_param.sv
// seq_mul_param: iterative shift-add multiplier that sits beside the ALU in
// the execute stage.
// The operands are converted to unsigned magnitudes when the operation is
// accepted. One partial product is added per CALC cycle. The sign is applied
// once, in FIN.
//
// Parameters
//   WIDTH      operand width, legal range 4..32; the product is 2*WIDTH bits
//   EARLY_EXIT 1 = leave CALC as soon as the remaining multiplier bits are 0
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   start    request, sampled only while idle
//   sgn      1 = two's complement operands, sampled with start
//   a, b     multiplicand / multiplier, sampled with start
//   busy     high from the accept edge up to the done edge
//   done     one-cycle pulse, product valid in that cycle
//   product  result, held until the next done
module seq_mul_param #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ma;      // multiplicand, pre-shifted by the bits consumed so far
  logic [WIDTH-1:0] r_mb;     // remaining multiplier bits
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_neg;
  logic            r_busy;
  logic            r_done;
  logic [PW-1:0]   r_product;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_mb_nxt;
  logic             w_last;

  // Negating the most negative value wraps back to itself. Read as unsigned,
  // that is exactly 2^(WIDTH-1), which is the magnitude we want.
  assign w_a_neg  = sgn & a[WIDTH-1];
  assign w_b_neg  = sgn & b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~a + WIDTH'(1)) : a;
  assign w_b_mag  = w_b_neg ? (~b + WIDTH'(1)) : b;

  assign w_mb_nxt = r_mb >> 1;
  assign w_last   = (r_cnt == CW'(1)) || (EARLY_EXIT && (w_mb_nxt == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_ma      <= '0;
      r_mb      <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_ma    <= {{WIDTH{1'b0}}, w_a_mag};
            r_mb    <= w_b_mag;
            r_neg   <= w_a_neg ^ w_b_neg;
            r_acc   <= '0;
            r_cnt   <= CW'(WIDTH);
            r_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          if (r_mb[0]) r_acc <= r_acc + r_ma;
          r_ma  <= r_ma << 1;
          r_mb  <= w_mb_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) r_state <= FIN;
        end
        FIN: begin
          // A zero magnitude negates to zero, so neg cannot produce -0.
          r_product <= r_neg ? (~r_acc + PW'(1)) : r_acc;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_seq_mul_param.sv
module tb_seq_mul_param;

  logic clk;
  logic rst;

  logic        st0, sg0, busy0, done0;
  logic [7:0]  a0, b0;
  logic [15:0] p0;
  logic        st1, sg1, busy1, done1;
  logic [7:0]  a1, b1;
  logic [15:0] p1;
  logic        st2, sg2, busy2, done2;
  logic [31:0] a2, b2;
  logic [63:0] p2;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb[$];
  logic [63:0] last_exp;

  seq_mul_param #(.WIDTH(8), .EARLY_EXIT(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(st0), .sgn(sg0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .product(p0));
  seq_mul_param #(.WIDTH(8), .EARLY_EXIT(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(st1), .sgn(sg1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .product(p1));
  seq_mul_param #(.WIDTH(32), .EARLY_EXIT(1'b0)) u2 (
    .clk(clk), .rst(rst), .start(st2), .sgn(sg2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .product(p2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic get_done(input int d);
    case (d)
      0: return done0;
      1: return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic [63:0] get_prod(input int d);
    case (d)
      0: return {48'd0, p0};
      1: return {48'd0, p1};
      default: return p2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic s, input logic [31:0] aa,
                       input logic [31:0] bb, input logic go);
    case (d)
      0: begin st0 = go; sg0 = s; a0 = aa[7:0]; b0 = bb[7:0]; end
      1: begin st1 = go; sg1 = s; a1 = aa[7:0]; b1 = bb[7:0]; end
      default: begin st2 = go; sg2 = s; a2 = aa; b2 = bb; end
    endcase
  endtask

  task automatic set_start(input int d, input logic go);
    case (d)
      0: st0 = go;
      1: st1 = go;
      default: st2 = go;
    endcase
  endtask

  // Called on a negedge: launch an op and record its expected product.
  task automatic launch(input int d, input logic s, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [63:0] exp);
    drive(d, s, aa, bb, 1'b1);
    sb.push_back(exp);
  endtask

  // lat = negedges from launch until done is seen (CALC cycles + 2).
  // inject pulses an ignored start with a=9,b=9 three cycles in.
  task automatic wait_done(input int d, input int lat, input logic inject, input string tag);
    int n;
    logic [63:0] exp;
    @(negedge clk);
    n = 1;
    set_start(d, 1'b0);
    check({tag, "_busy"}, {63'd0, get_busy(d)}, 64'd1);
    while (!get_done(d) && n < 200) begin
      if (inject && n == 3) drive(d, 1'b0, 32'd9, 32'd9, 1'b1);
      else set_start(d, 1'b0);
      @(negedge clk);
      n++;
    end
    set_start(d, 1'b0);
    check({tag, "_lat"}, 64'(n), 64'(lat));
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    last_exp = exp;
    check({tag, "_prod"}, get_prod(d), exp);
    check({tag, "_busy_off"}, {63'd0, get_busy(d)}, 64'd0);
  endtask

  task automatic after_done(input int d, input string tag);
    @(negedge clk);
    check({tag, "_pulse"}, {63'd0, get_done(d)}, 64'd0);
    check({tag, "_hold"}, get_prod(d), last_exp);
  endtask

  initial begin
    logic seen;
    rst = 1'b0;
    drive(0, 1'b0, 0, 0, 1'b0);
    drive(1, 1'b0, 0, 0, 1'b0);
    drive(2, 1'b0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_busy", {61'd0, busy0, busy1, busy2}, 64'd0);
    check("rst_done", {61'd0, done0, done1, done2}, 64'd0);
    check("rst_prod", get_prod(0) | get_prod(1) | get_prod(2), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Unsigned 8-bit, with an ignored start mid-op, then back-to-back.
    launch(0, 1'b0, 200, 150, 64'h7530);
    wait_done(0, 10, 1'b1, "u200x150");
    launch(0, 1'b0, 9, 9, 64'd81);   // start in the done cycle
    wait_done(0, 10, 1'b0, "b2b9x9");
    after_done(0, "b2b9x9");

    // Signed 8-bit corners.
    launch(0, 1'b1, 32'h80, 32'h80, 64'h4000);
    wait_done(0, 10, 1'b0, "s80x80");
    after_done(0, "s80x80");
    launch(0, 1'b1, 32'hFD, 32'd5, 64'hFFF1);
    wait_done(0, 10, 1'b0, "sm3x5");
    after_done(0, "sm3x5");

    // Early exit.
    launch(1, 1'b0, 7, 3, 64'd21);
    wait_done(1, 4, 1'b0, "ee7x3");
    after_done(1, "ee7x3");
    launch(1, 1'b0, 7, 0, 64'd0);
    wait_done(1, 3, 1'b0, "ee7x0");
    launch(1, 1'b1, 32'hFD, 0, 64'd0);
    wait_done(1, 3, 1'b0, "eeneg0");
    launch(1, 1'b1, 32'hFF, 32'h80, 64'h0080);
    wait_done(1, 10, 1'b0, "eem1x80");

    // Asynchronous reset mid-CALC abandons the op.
    drive(0, 1'b0, 100, 3, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy0}, 64'd0);
    check("arst_done", {63'd0, done0}, 64'd0);
    check("arst_prod", get_prod(0), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done0) seen = 1'b1;
    end
    check("arst_nodone", {63'd0, seen}, 64'd0);
    launch(0, 1'b0, 255, 255, 64'hFE01);
    wait_done(0, 10, 1'b0, "u255x255");

    // 32-bit signed.
    launch(2, 1'b1, 32'hFFFFFFFF, 32'h7FFFFFFF, 64'hFFFFFFFF80000001);
    wait_done(2, 34, 1'b0, "w32m1");
    after_done(2, "w32m1");
    launch(2, 1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000);
    wait_done(2, 34, 1'b0, "w32min");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_mul_param.md
Name: seq_mul_param

Overview:
- Parametrised iterative shift-add multiplier for the CPU execute stage.
- Next generation of the fixed-width multiplier: configurable width, per-operation signed/unsigned mode, optional early termination, explicit start/busy/done handshake.
- Sits beside the ALU; the execute stage pulses start and waits for done before selecting the product.

Parameters:
- WIDTH, 16: operand width in bits; product is 2*WIDTH. Legal range 4..32.
- EARLY_EXIT, 0: 1 = stop iterating once the remaining multiplier bits are all zero.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- sgn  in  1  1 = operands are two's complement, 0 = unsigned; sampled with start.
- a  in  WIDTH  multiplicand; sampled with start.
- b  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high from the edge after start is accepted until the done edge.
- done  out  1  one-cycle pulse; product valid in that cycle.
- product  out  2*WIDTH  result; holds its value until the next done.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, done=0, product=0, all internal registers 0. Reset mid-operation abandons the operation; no done is produced.
- States: IDLE, CALC, FIN.
- IDLE, start=1 at edge E0:
  - Latch ma=|a| and mb=|b| as WIDTH-bit unsigned magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1).
  - Latch neg = sgn & (a[MSB] ^ b[MSB]).
  - acc=0, cnt=WIDTH, busy=1, state=CALC.
- CALC, each edge:
  - If mb[0], acc += ma << (WIDTH-cnt), computed at 2*WIDTH bits with no overflow.
  - mb >>= 1, cnt -= 1.
  - Leave for FIN when cnt reaches 0.
  - With EARLY_EXIT=1, also leave for FIN when the shifted mb becomes 0. CALC always lasts at least 1 cycle.
- FIN, one edge:
  - product = neg ? -acc : acc (2*WIDTH two's complement).
  - done=1, busy=0, state=IDLE.
- Latency, EARLY_EXIT=0: done is high in the cycle after edge E0+WIDTH+1 (WIDTH CALC cycles plus 1 FIN cycle).
- Latency, EARLY_EXIT=1: CALC lasts max(1, index of highest set bit of |b| + 1) cycles.
- done clears at the following edge unless a new FIN occurs then.
- start while busy=1: ignored, with no effect on the operation in progress.
- start in the done cycle: accepted (state is IDLE), giving back-to-back operation. done clears, busy rises.
- a=0 or b=0: product is 0 with normal latency, or 1 CALC cycle when EARLY_EXIT=1. neg only sets the sign of a zero product, and -0 = 0.
- Unsigned products never overflow.
- The signed range is fully representable, including (-2^(W-1))^2 = 2^(2W-2).

Test Plan:
- WIDTH=8, EARLY_EXIT=0, sgn=0, a=200, b=150, start 1 cycle -> busy for 9 cycles, then done 1 cycle with product=0x7530 (30000).
- WIDTH=8, sgn=1, a=0x80, b=0x80 -> product=0x4000. Then a=0xFD (-3), b=5 -> product=0xFFF1 (-15).
- WIDTH=8, EARLY_EXIT=1, sgn=0, a=7, b=3 -> done after 2 CALC cycles + FIN, product=21. Then b=0 -> 1 CALC cycle, product=0.
- Pulse start again 3 cycles into an op with a=9, b=9 -> ignored, and the original product is unchanged. Assert start again in the done cycle with a=9, b=9 -> second done follows with product=81.
- Drive rst=0 asynchronously mid-CALC -> busy, done and product go to 0 immediately with no done pulse. After release, a=255, b=255, sgn=0 -> product=0xFE01.
- WIDTH=32, sgn=1, a=0xFFFFFFFF, b=0x7FFFFFFF -> after 33 cycles product=0xFFFFFFFF80000001.
